// File: rtl/lsu_axi_master.sv
`default_nettype none
// ============================================================================
// Module      : lsu_axi_master
// Description : Bridges the MEM stage's level-held load/store request and its
//               one-cycle finish handshake onto single AXI4-Lite master
//               transactions. One transaction in flight, no reordering.
//               Optional bus watchdog enabled by defining LSU_AXI_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_axi_master #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    // MEM stage side
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                wr_req,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
    output logic                finish,
    output logic                err,
    // AXI4-Lite write address channel
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [2:0]          awprot,
    // AXI4-Lite write data channel
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    // AXI4-Lite write response channel
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp,
    // AXI4-Lite read address channel
    output logic                arvalid,
    input  logic                arready,
    output logic [ADDR_W-1:0]   araddr,
    output logic [2:0]          arprot,
    // AXI4-Lite read data channel
    input  logic                rvalid,
    output logic                rready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp
);

    localparam int c_STRB_W = DATA_W / 8;

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_RD_ADDR = 3'd1;
    localparam logic [2:0] c_S_RD_DATA = 3'd2;
    localparam logic [2:0] c_S_WR_REQ  = 3'd3;
    localparam logic [2:0] c_S_WR_RESP = 3'd4;
    localparam logic [2:0] c_S_DONE    = 3'd5;

    logic [2:0]          r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_STRB_W-1:0] r_wstrb;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_arvalid;
    logic                r_rready;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_bready;
    logic                r_finish;
    logic                r_err;
    logic                r_aw_done;
    logic                r_w_done;

    // Write-channel handshakes; AW and W may complete in either order or together.
    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_ok;
    logic w_w_ok;

    assign w_aw_hs = r_awvalid & awready;
    assign w_w_hs  = r_wvalid & wready;
    assign w_aw_ok = r_aw_done | w_aw_hs;
    assign w_w_ok  = r_w_done | w_w_hs;

`ifdef LSU_AXI_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_tmo_cnt;
    logic               w_hold;
    logic               w_tmo_hit;

    // A waiting state holds when its channel handshake is not completing this cycle.
    always_comb begin
        w_hold = 1'b0;
        case (r_state)
            c_S_RD_ADDR: w_hold = ~arready;
            c_S_RD_DATA: w_hold = ~rvalid;
            c_S_WR_REQ:  w_hold = ~(w_aw_ok & w_w_ok);
            c_S_WR_RESP: w_hold = ~bvalid;
            default:     w_hold = 1'b0;
        endcase
    end

    assign w_tmo_hit = w_hold & (r_tmo_cnt == c_TMO_LAST);

    // Cycles spent in the current wait state; restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst || !w_hold) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

    // Transaction sequencer with registered AXI and MEM-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rd_data <= '0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_finish  <= 1'b0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    r_err <= 1'b0;
                    // Store takes priority when both requests are raised together.
                    if (wr_req) begin
                        r_addr    <= wr_addr;
                        r_wdata   <= wr_data;
                        r_wstrb   <= wr_strb;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= c_S_WR_REQ;
                    end else if (rd_req) begin
                        r_addr    <= rd_addr;
                        r_arvalid <= 1'b1;
                        r_state   <= c_S_RD_ADDR;
                    end
                end
                c_S_RD_ADDR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= c_S_RD_DATA;
                    end
                end
                c_S_RD_DATA: begin
                    if (rvalid) begin
                        r_rready  <= 1'b0;
                        r_rd_data <= rdata;
                        r_err     <= (rresp != 2'b00);
                        r_finish  <= 1'b1;
                        r_state   <= c_S_DONE;
                    end
                end
                c_S_WR_REQ: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_ok && w_w_ok) begin
                        r_bready <= 1'b1;
                        r_state  <= c_S_WR_RESP;
                    end
                end
                c_S_WR_RESP: begin
                    if (bvalid) begin
                        r_bready <= 1'b0;
                        r_err    <= (bresp != 2'b00);
                        r_finish <= 1'b1;
                        r_state  <= c_S_DONE;
                    end
                end
                c_S_DONE: begin
                    // MEM releases its request on this edge, so IDLE sees it low.
                    r_err   <= 1'b0;
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
`ifdef LSU_AXI_TIMEOUT_EN
            // Hung bus: abandon the access and report it as an error completion.
            if (w_tmo_hit) begin
                r_arvalid <= 1'b0;
                r_rready  <= 1'b0;
                r_awvalid <= 1'b0;
                r_wvalid  <= 1'b0;
                r_bready  <= 1'b0;
                if ((r_state == c_S_RD_ADDR) || (r_state == c_S_RD_DATA)) begin
                    r_rd_data <= '1;
                end
                r_err    <= 1'b1;
                r_finish <= 1'b1;
                r_state  <= c_S_DONE;
            end
`endif
        end
    end

    assign rd_data = r_rd_data;
    assign finish  = r_finish;
    assign err     = r_err;
    assign awvalid = r_awvalid;
    assign awaddr  = r_addr;
    assign awprot  = 3'b000;
    assign wvalid  = r_wvalid;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign bready  = r_bready;
    assign arvalid = r_arvalid;
    assign araddr  = r_addr;
    assign arprot  = 3'b000;
    assign rready  = r_rready;

endmodule
`default_nettype wire
